// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : posit_pkg
// Description : Shared posit definitions: log2 helper, special encodings and
//               the unpacked result-field bundle from the alignment stage.
// Revision    : 1.0 - initial release
// ============================================================================
package posit_pkg;

    // Ceiling log2 for elaboration-time width computation
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int POSIT_N  = 8;
    localparam int POSIT_ES = 3;
    localparam int POSIT_RS = log2(POSIT_N);

    // Special words and saturation bodies for the default format
    localparam logic [POSIT_N-1:0] c_nar_word    = {1'b1, {(POSIT_N-1){1'b0}}};
    localparam logic [POSIT_N-1:0] c_zero_word   = '0;
    localparam logic [POSIT_N-2:0] c_maxpos_body = '1;
    localparam logic [POSIT_N-2:0] c_minpos_body = {{(POSIT_N-2){1'b0}}, 1'b1};

    // Unpacked result fields handed over by the alignment/arithmetic stage
    typedef struct packed {
        logic                       sign;
        logic signed [POSIT_RS:0]   regime;
        logic [POSIT_ES-1:0]        exp;
        logic [POSIT_N-1:0]         mant;
        logic                       zero;
        logic                       nar;
    } posit_fields_t;

endpackage
`default_nettype wire

// File: rtl/posit_round_finish.sv
`default_nettype none
// ============================================================================
// Module      : posit_round_finish
// Description : Combinational posit finishing: round-nearest-even on the
//               packed body, saturation to maxpos/minpos, sign negation and
//               special-value override.
// Revision    : 1.0 - initial release
// ============================================================================
module posit_round_finish #(
    parameter int N = 8
) (
    input  logic [N-2:0] body,
    input  logic         guard,
    input  logic         sticky,
    input  logic         sign,
    input  logic         zero,
    input  logic         nar,
    input  logic         sat_max,
    input  logic         sat_min,
    output logic [N-1:0] posit
);

    logic         w_round_up;
    logic [N-1:0] w_sum;
    logic         w_carry;
    logic [N-2:0] w_rounded;
    logic [N-2:0] w_body;
    logic [N-1:0] w_word;

    // Increment on guard when the discarded part is above half or the tie
    // must be broken toward an even lsb; the carry may ripple into exp/regime
    assign w_round_up = guard & (sticky | body[0]);
    assign w_sum      = {1'b0, body} + {{(N-1){1'b0}}, w_round_up};
    assign w_carry    = w_sum[N-1];
    assign w_rounded  = w_sum[N-2:0];

    // Saturate, then form the unsigned word and apply sign and specials
    always_comb begin
        w_body = w_rounded;
        if (sat_max || w_carry) begin
            w_body = '1;
        end else if (sat_min || (w_rounded == '0)) begin
            w_body = {{(N-2){1'b0}}, 1'b1};
        end

        w_word = {1'b0, w_body};
        posit  = sign ? (~w_word + N'(1)) : w_word;

        if (nar) begin
            posit = {1'b1, {(N-1){1'b0}}};
        end else if (zero) begin
            posit = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/posit_result_encoder.sv
`default_nettype none
// ============================================================================
// Module      : posit_result_encoder
// Description : Two-stage posit packer. Stage 1 builds the regime run and
//               extracts body/guard/sticky; stage 2 rounds, saturates and
//               negates. Valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module posit_result_encoder
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES,
    parameter int RS = log2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic signed [RS:0]  in_regime,
    input  logic [ES-1:0]       in_exp,
    input  logic [N-1:0]        in_mant,
    input  logic                in_zero,
    input  logic                in_nar,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_posit
);

    // The seed is shifted by at most 2^RS-1 places; padding of 2^RS zeros
    // below the fraction keeps every shifted-out bit inside the sticky field
    localparam int c_pad = 1 << RS;
    localparam int c_vw  = 2 + ES + (N - 1) + c_pad;

    localparam logic signed [RS:0] c_kmax = (RS+1)'(N - 2);
    localparam logic signed [RS:0] c_kmin = (RS+1)'(-(N - 1));

    logic                    w_neg;
    logic [RS-1:0]           w_shamt;
    logic signed [c_vw-1:0]  w_seed;
    logic signed [c_vw-1:0]  w_run;
    logic [N-2:0]            w_body;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_sat_max;
    logic                    w_sat_min;
    logic                    w_unused_hidden;
    logic                    w_s2_free;
    logic                    w_in_ready;
    logic [N-1:0]            w_posit;

    logic                    r_s1_valid;
    logic [N-2:0]            r_s1_body;
    logic                    r_s1_guard;
    logic                    r_s1_sticky;
    logic                    r_s1_sign;
    logic                    r_s1_zero;
    logic                    r_s1_nar;
    logic                    r_s1_sat_max;
    logic                    r_s1_sat_min;
    logic                    r_out_valid;
    logic [N-1:0]            r_out_posit;

    // The hidden one is implied by the format and never stored
    assign w_unused_hidden = in_mant[N-1];

    // Regime run via arithmetic shift: a "10" prefix filled with ones gives
    // k+1 ones then 0; a "01" prefix filled with zeros gives -k zeros then 1.
    // For negative k the shift is -k-1, which is simply ~k.
    assign w_neg    = in_regime[RS];
    assign w_shamt  = w_neg ? ~in_regime[RS-1:0] : in_regime[RS-1:0];
    assign w_seed   = {~w_neg, w_neg, in_exp, in_mant[N-2:0], {c_pad{1'b0}}};
    assign w_run    = w_seed >>> w_shamt;

    assign w_body   = w_run[c_vw-1 -: N-1];
    assign w_guard  = w_run[c_vw-N];
    assign w_sticky = |w_run[c_vw-N-1:0];

    assign w_sat_max = (in_regime >= c_kmax);
    assign w_sat_min = (in_regime <= c_kmin);

    assign w_s2_free  = !r_out_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_free;

    // Stage-1 slot: capture packed fields on every accepted input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_body    <= '0;
            r_s1_guard   <= 1'b0;
            r_s1_sticky  <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_zero    <= 1'b0;
            r_s1_nar     <= 1'b0;
            r_s1_sat_max <= 1'b0;
            r_s1_sat_min <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_body    <= w_body;
                r_s1_guard   <= w_guard;
                r_s1_sticky  <= w_sticky;
                r_s1_sign    <= in_sign;
                r_s1_zero    <= in_zero;
                r_s1_nar     <= in_nar;
                r_s1_sat_max <= w_sat_max;
                r_s1_sat_min <= w_sat_min;
            end
        end
    end

    posit_round_finish #(
        .N (N)
    ) u_round_finish (
        .body    (r_s1_body),
        .guard   (r_s1_guard),
        .sticky  (r_s1_sticky),
        .sign    (r_s1_sign),
        .zero    (r_s1_zero),
        .nar     (r_s1_nar),
        .sat_max (r_s1_sat_max),
        .sat_min (r_s1_sat_min),
        .posit   (w_posit)
    );

    // Output register: load from stage 1 whenever the slot is free or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_posit <= '0;
        end else if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_posit <= w_posit;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_posit = r_out_posit;

endmodule
`default_nettype wire

// File: tb/tb_posit_result_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_posit_result_encoder
// Description : Scoreboard bench for posit_result_encoder (N=8, ES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_result_encoder;
    import posit_pkg::*;

    localparam int N  = 8;
    localparam int ES = 3;
    localparam int RS = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_sign = 1'b0;
    logic signed [RS:0] in_regime = '0;
    logic [ES-1:0]      in_exp = '0;
    logic [N-1:0]       in_mant = '0;
    logic               in_zero = 1'b0;
    logic               in_nar = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [N-1:0]       out_posit;

    logic [N-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic         stall = 1'b0;
    logic [N-1:0] stall_val = '0;
    logic         rnd_bp = 1'b0;

    always #5 clk = ~clk;

    posit_result_encoder #(.N(N), .ES(ES), .RS(RS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_regime (in_regime),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: lay the posit bit string out as a queue of bits, then round
    // the first N-1 bits as an integer and apply the saturation rules.
    function automatic logic [N-1:0] ref_encode(input posit_fields_t f);
        bit q[$];
        int k, body, guard, sticky;
        if (f.nar)  return 8'h80;
        if (f.zero) return 8'h00;
        k = $signed(f.regime);
        if (k >= 0) begin
            for (int i = 0; i < k + 1; i++) q.push_back(1'b1);
            q.push_back(1'b0);
        end else begin
            for (int i = 0; i < -k; i++) q.push_back(1'b0);
            q.push_back(1'b1);
        end
        for (int i = ES - 1; i >= 0; i--) q.push_back(f.exp[i]);
        for (int i = N - 2; i >= 0; i--) q.push_back(f.mant[i]);
        body = 0;
        for (int i = 0; i < N - 1; i++) body = body * 2 + int'(q[i]);
        guard  = int'(q[N-1]);
        sticky = 0;
        for (int i = N; i < q.size(); i++) if (q[i]) sticky = 1;
        if (guard == 1 && (sticky == 1 || (body % 2) == 1)) body = body + 1;
        if (k >= N - 2 || body > 127) body = 127;
        else if (k <= -(N - 1) || body == 0) body = 1;
        if (f.sign) body = (256 - body) % 256;
        return body[N-1:0];
    endfunction

    function automatic posit_fields_t mk(input bit s, input int k, input int e, input int m,
                                         input bit z, input bit nr);
        posit_fields_t f;
        f.sign   = s;
        f.regime = k[RS:0];
        f.exp    = e[ES-1:0];
        f.mant   = m[N-1:0];
        f.zero   = z;
        f.nar    = nr;
        return f;
    endfunction

    function automatic posit_fields_t rnd_fields();
        posit_fields_t f;
        f.sign   = 1'($urandom_range(0, 1));
        f.regime = 4'($urandom_range(0, 15));
        f.exp    = 3'($urandom_range(0, 7));
        f.mant   = 8'h80 | 8'($urandom_range(0, 127));
        f.zero   = ($urandom_range(0, 15) == 0);
        f.nar    = ($urandom_range(0, 15) == 0);
        return f;
    endfunction

    // Present one input until accepted; expectation is queued at acceptance
    task automatic send(input posit_fields_t f, input logic [N-1:0] expv);
        bit done;
        done      = 1'b0;
        in_sign   = f.sign;
        in_regime = f.regime;
        in_exp    = f.exp;
        in_mant   = f.mant;
        in_zero   = f.zero;
        in_nar    = f.nar;
        in_valid  = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expv);
                done = 1'b1;
            end
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on each output handshake, and check that a
    // stalled output holds its value
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_posit", out_posit, stall_val);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", out_posit, 32'hFFFF);
                else check("posit", out_posit, exp_q.pop_front());
            end
            stall     = out_valid && !out_ready;
            stall_val = out_posit;
        end
    end

    // Random downstream backpressure while enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_posit", out_posit, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Latency: accepted at edge E1, visible only after E2
        send(mk(0, 0, 0, 'h80, 0, 0), 8'h40);
        @(negedge clk);
        check("latency_early", out_valid, 0);
        @(negedge clk);
        check("latency_valid", out_valid, 1);
        wait_drain();

        // Directed encodings
        send(mk(1, 0, 0, 'h80, 0, 0), 8'hC0);
        send(mk(0, 1, 0, 'h80, 0, 0), 8'h60);
        send(mk(0, 6, 0, 'h80, 0, 0), 8'h7F);
        send(mk(0, 7, 0, 'h80, 0, 0), 8'h7F);
        send(mk(0, 0, 0, 'hB0, 0, 0), 8'h42);
        send(mk(0, 0, 0, 'h90, 0, 0), 8'h40);
        send(mk(0, 0, 0, 'h98, 0, 0), 8'h41);
        send(mk(0, -7, 0, 'h80, 0, 0), 8'h01);
        send(mk(1, -7, 0, 'h80, 0, 0), 8'hFF);
        send(mk(1, 3, 5, 'hC7, 0, 1), 8'h80);
        send(mk(1, -2, 6, 'hA5, 1, 0), 8'h00);
        send(mk(0, 2, 1, 'hF1, 1, 1), 8'h80);
        send(mk(0, 5, 7, 'hFF, 0, 0), ref_encode(mk(0, 5, 7, 'hFF, 0, 0)));
        wait_drain();

        // Backpressure: 4 back-to-back inputs, output stalled for 3 cycles
        fork
            begin
                send(mk(0, 2, 3, 'h81, 0, 0), ref_encode(mk(0, 2, 3, 'h81, 0, 0)));
                send(mk(1, -3, 4, 'hE3, 0, 0), ref_encode(mk(1, -3, 4, 'hE3, 0, 0)));
                send(mk(0, -1, 7, 'h9F, 0, 0), ref_encode(mk(0, -1, 7, 'h9F, 0, 0)));
                send(mk(1, 4, 2, 'hD5, 0, 0), ref_encode(mk(1, 4, 2, 'hD5, 0, 0)));
            end
            begin
                out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", in_ready, 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Randomized traffic with random backpressure and input gaps
        rnd_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            posit_fields_t f;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            f = rnd_fields();
            send(f, ref_encode(f));
        end
        rnd_bp = 1'b0;
        repeat (2) @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain();

        // Reset with results in flight: they must vanish
        out_ready = 1'b0;
        send(mk(0, 1, 1, 'h88, 0, 0), 8'h00);
        send(mk(1, 1, 1, 'h88, 0, 0), 8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_posit", out_posit, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("post_rst_no_output", seen, 0);
        @(posedge clk);
        #1;

        // Recovery after reset
        send(mk(1, 1, 0, 'h80, 0, 0), 8'hA0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/posit_result_encoder.md
Name: posit_result_encoder

Overview:
- Packing end of the posit add datapath. Accepts the unpacked result fields from the alignment/arithmetic stage: sign, combined regime value, exponent and normalised mantissa.
- Builds the regime run, appends exponent and fraction, rounds to nearest-even, applies saturation and two's complement, and emits the N-bit posit word.
- 2-stage pipeline with valid/ready handshake on both sides.

Parameters:
- N, 8, posit word width.
- ES, 3, exponent field width.
- RS, log2(N), regime-value magnitude width. in_regime is RS+1 bits signed.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept the input this cycle.
- in_sign  in  1  result sign (1 = negative).
- in_regime  in  RS+1  signed regime value k.
- in_exp  in  ES  exponent field e.
- in_mant  in  N  mantissa; bit N-1 = hidden 1; bits N-2:0 = fraction.
- in_zero  in  1  result is exact zero.
- in_nar  in  1  result is NaR.
- out_valid  out  1  out_posit valid.
- out_ready  in  1  downstream accepts.
- out_posit  out  N  encoded posit.

Behaviour:
- Reset (async assert, sync deassert): s1_valid = 0, out_valid = 0, out_posit = 0. in_ready = 1 once reset is released.
- Handshake:
  - A transfer occurs when valid && ready.
  - in_ready = !s1_valid || (!out_valid || out_ready). The stage-1 slot is free or draining.
  - Stage 2 loads when s1_valid && (!out_valid || out_ready).
  - out_posit and out_valid hold stable while out_valid && !out_ready.
  - No combinational path from in_valid to out_valid.
- Latency: 2 cycles from input acceptance to out_valid with no stall. Throughput is 1 result per cycle.
- Stage 1 (pack):
  - Regime run for k >= 0: (k+1) ones then a 0.
  - Regime run for k < 0: (-k) zeros then a 1.
  - Concatenate regime run, in_exp, and in_mant[N-2:0] into an extended string. Keep the top N-1 bits as the body.
  - guard = next bit below the body. sticky = OR of all remaining bits.
  - Register body, guard, sticky, sign, zero, nar.
- Stage 2 (round/finish):
  - Round-nearest-even: increment the body if guard && (sticky || body[0]). A carry may ripple into the exponent/regime; this is legal and monotonic.
  - Clamp: if k >= N-2, or the rounded body overflows, body = all ones (maxpos).
  - Clamp: if k <= -(N-1), or the body is all zeros after rounding, body = 1 (minpos). A nonzero result never encodes to 0.
  - out_posit = {0, body}. If sign = 1, out_posit = two's complement of that word.
- Specials:
  - in_nar has priority: out = 1 followed by N-1 zeros.
  - Otherwise in_zero: out = all zeros.
  - Sign, regime, exp and mant are ignored for specials.
- in_exp is unsigned. The value represented is (-1)^s * 2^(k*2^ES + e) * 1.f.
- Simultaneous accept-in and drain-out in the same cycle: both occur, no bubble.
- Reset mid-operation: in-flight results are discarded; no partial output appears after reset.

Decomposition:
- posit_pkg holds:
  - the log2 function;
  - constants: NAR word, ZERO word, MAXPOS body, MINPOS body;
  - a typedef for the unpacked field bundle (sign, regime, exp, mant, zero, nar) shared with the alignment stage.
- One sub-module: posit_round_finish. It is combinational stage 2 (RNE, clamp, negate), reused later by the multiplier path.

Test Plan (N=8, ES=3):
1. 1.0: k=0, e=0, mant=8'h80, sign 0 -> 8'h40 two cycles later. With sign 1 -> 8'hC0.
2. Regime growth: k=1, e=0, mant=8'h80 -> 8'h60. k=6 -> 8'h7F. k=7 -> 8'h7F (saturation).
3. RNE tie:
   - mant=8'hB0 (1.011), k=0, e=0 -> 8'h42 (round up, lsb was 1).
   - mant=8'h90 -> 8'h40 (tie, lsb 0, no change).
   - mant=8'h98 -> 8'h41 (sticky set, round up).
4. Underflow: k=-7 -> 8'h01. Same input with sign 1 -> 8'hFF. The result is never 0.
5. Specials: in_nar=1 -> 8'h80, regardless of other fields. in_zero=1 -> 8'h00. in_nar and in_zero both set -> 8'h80.
6. Backpressure: stream 4 back-to-back inputs with out_ready low for 3 cycles mid-stream.
   - in_ready drops when both stages are full.
   - out_posit holds stable while stalled.
   - All 4 results arrive in order with no loss or duplication.
   - Assert rst_n low mid-stream: out_valid goes to 0 immediately (asynchronously).
